// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, tick-sampled stability filter,
// one-clk press/release pulses and optional auto-repeat, per button.
module button_debounce #(
  parameter int unsigned N            = 2,
  parameter int unsigned STABLE_COUNT = 4,
  parameter int unsigned REPEAT_EN    = 0,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sampleTick,
  input  logic [N-1:0] btnRaw,
  output logic [N-1:0] btnLevel,
  output logic [N-1:0] btnPress,
  output logic [N-1:0] btnRelease
);

  localparam int unsigned CW   = $clog2(STABLE_COUNT + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_COUNT - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } filt_state_e;

  logic [N-1:0] s1;
  logic [N-1:0] s2;

  filt_state_e  state_q [N];
  filt_state_e  state_d [N];
  logic [CW-1:0] cnt_q  [N];
  logic [CW-1:0] cnt_d  [N];
  logic [RW-1:0] rcnt_q [N];
  logic [RW-1:0] rcnt_d [N];

  logic [N-1:0] rep_q;
  logic [N-1:0] rep_d;
  logic [N-1:0] level_d;
  logic [N-1:0] press_d;
  logic [N-1:0] release_d;
  logic [N-1:0] accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      btnLevel   <= '0;
      btnPress   <= '0;
      btnRelease <= '0;
      rep_q      <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
        rcnt_q[i]  <= '0;
      end
    end else begin
      s1         <= btnRaw;
      s2         <= s1;
      btnLevel   <= level_d;
      btnPress   <= press_d;
      btnRelease <= release_d;
      rep_q      <= rep_d;
      for (int unsigned i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
    end
  end

  always_comb begin
    level_d   = btnLevel;
    press_d   = '0;
    release_d = '0;
    rep_d     = rep_q;
    accept    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rcnt_d[i]  = rcnt_q[i];
      if (sampleTick) begin
        if (s2[i] == btnLevel[i]) begin
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          accept[i]    = 1'b1;
          level_d[i]   = s2[i];
          state_d[i]   = STABLE;
          cnt_d[i]     = '0;
          press_d[i]   = s2[i];
          release_d[i] = ~s2[i];
          rcnt_d[i]    = '0;
          rep_d[i]     = 1'b0;
        end else begin
          // count is always 0 while STABLE, so entering PENDING starts at 1
          state_d[i] = PENDING;
          cnt_d[i]   = (state_q[i] == PENDING) ? cnt_q[i] + 1'b1 : CW'(1);
        end

        // acceptance (press or release) takes priority over a due repeat
        if ((REPEAT_EN != 0) && btnLevel[i] && !accept[i]) begin
          if (rcnt_q[i] == (rep_q[i] ? RATE_LAST : DELAY_LAST)) begin
            press_d[i] = 1'b1;
            rcnt_d[i]  = '0;
            rep_d[i]   = 1'b1;
          end else begin
            rcnt_d[i] = rcnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule
